avalon_spi_master_mc: RTL and testbench

- Single-clock, parametrised successor to the current Avalon-MM SPI bridge.
- One Avalon-MM slave feeds an internal TX FIFO and drains an internal RX FIFO; an SPI master engine sits between them.
- Adds programmable CPOL/CPHA, a runtime clock divider, NUM_SS slave selects, sticky overflow flags and a maskable irq.
- Sits directly on the system Avalon bus; no PLL and no dual-clock FIFOs.

---
 rtl/avalon_spi_master_mc.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_avalon_spi_master_mc.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_spi_master_mc.sv
// Avalon-MM SPI master: TX/RX first-word-fall-through FIFOs, CPOL/CPHA, runtime divider, NUM_SS selects, irq.
// Define SPI_LOOPBACK_EN to build the internal mosi->miso loopback controlled by CONTROL[6].

module avalon_spi_master_mc_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full,
    output logic         drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & ~do_push;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; pointers and count alone define the contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module avalon_spi_master_mc #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_SS     = 4,
    parameter int DIV_W      = 8
) (
    input  logic              clk,
    input  logic              hard_reset,
    input  logic [7:0]        address,
    input  logic              chip_select,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              wait_request,
    output logic              irq,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_SS-1:0] ss_n
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam int EDGES = 2 * DATA_W;
    localparam int EW    = $clog2(EDGES + 1);

    state_t state, next_state;

    logic              c_enable, c_cpol, c_cpha, c_ie_rx, c_ie_idle, c_ie_err, c_loop;
    logic [3:0]        c_ss_sel;
    logic [DIV_W-1:0]  c_div;
    logic              tx_ovf, rx_ovr;

    logic              cpha_l;
    logic [DIV_W-1:0]  div_l, hcnt;
    logic [EW-1:0]     ecnt;
    logic [DATA_W-1:0] tx_sr, rx_sr, rx_word;
    logic              sclk_q, mosi_q, sample_bit;
    logic [NUM_SS-1:0] ss_n_q;

    logic              busy, half_done, last_edge, toggle, leading, trailing, sample_ev, shift_ev;

    logic              tx_push, tx_pop, tx_empty, tx_full, tx_drop;
    logic              rx_push, rx_pop, rx_empty, rx_full, rx_drop;
    logic [DATA_W-1:0] tx_head, rx_head;

    logic [1:0]        reg_addr;
    logic              wr_en, rd_first, rd_last, rd_phase, rd_pop_ok;
    logic [31:0]       rd_mux;
    logic              unused_bits;

    assign reg_addr     = address[1:0];
    assign wr_en        = chip_select & write;
    assign rd_first     = chip_select & read & ~rd_phase;
    assign rd_last      = chip_select & read & rd_phase;
    assign wait_request = rd_first;
    assign tx_push      = wr_en && (reg_addr == 2'd0);
    assign rx_pop       = rd_last & rd_pop_ok;
    assign unused_bits  = ^{address[7:2], write_data};

    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign ss_n = ss_n_q;
    assign busy = (state != IDLE);

    avalon_spi_master_mc_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(hard_reset), .push(tx_push), .wdata(write_data[DATA_W-1:0]),
        .pop(tx_pop), .rdata(tx_head), .empty(tx_empty), .full(tx_full), .drop(tx_drop)
    );

    avalon_spi_master_mc_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(hard_reset), .push(rx_push), .wdata(rx_word),
        .pop(rx_pop), .rdata(rx_head), .empty(rx_empty), .full(rx_full), .drop(rx_drop)
    );

    function automatic logic [NUM_SS-1:0] ss_decode(input logic [3:0] sel);
        logic [NUM_SS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (int'(sel) == i) v[i] = 1'b0;
        end
        return v;
    endfunction

    // Read handshake: snapshot the register in the wait cycle, pop RX only in the data cycle.
    always_ff @(posedge clk) begin
        if (hard_reset) begin
            rd_phase  <= 1'b0;
            rd_pop_ok <= 1'b0;
            read_data <= '0;
        end else begin
            rd_phase  <= rd_first;
            rd_pop_ok <= rd_first && (reg_addr == 2'd1) && !rx_empty;
            if (rd_first) read_data <= rd_mux;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            2'd1: rd_mux[DATA_W-1:0] = rx_empty ? '0 : rx_head;
            2'd2: rd_mux[6:0] = {rx_ovr, tx_ovf, rx_full, rx_empty, tx_full, tx_empty, busy};
            2'd3: begin
                rd_mux[5:0]          = {c_ie_err, c_ie_idle, c_ie_rx, c_cpha, c_cpol, c_enable};
                rd_mux[6]            = c_loop;
                rd_mux[11:8]         = c_ss_sel;
                rd_mux[16 +: DIV_W]  = c_div;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (hard_reset) begin
            {c_enable, c_cpol, c_cpha, c_ie_rx, c_ie_idle, c_ie_err} <= '0;
            c_ss_sel <= '0;
            c_div    <= '0;
            tx_ovf   <= 1'b0;
            rx_ovr   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_en && reg_addr == 2'd3) begin
                {c_ie_err, c_ie_idle, c_ie_rx, c_cpha, c_cpol, c_enable} <= write_data[5:0];
                c_ss_sel <= write_data[11:8];
                c_div    <= write_data[16 +: DIV_W];
            end
            // A new overflow in the same cycle as the clear wins.
            if (tx_drop) tx_ovf <= 1'b1;
            else if (wr_en && reg_addr == 2'd2 && write_data[5]) tx_ovf <= 1'b0;
            if (rx_drop) rx_ovr <= 1'b1;
            else if (wr_en && reg_addr == 2'd2 && write_data[6]) rx_ovr <= 1'b0;
            irq <= (c_ie_rx & ~rx_empty) | (c_ie_idle & tx_empty & ~busy)
                 | (c_ie_err & (tx_ovf | rx_ovr));
        end
    end

`ifdef SPI_LOOPBACK_EN
    logic loop_l;
    always_ff @(posedge clk) begin
        if (hard_reset) begin
            c_loop <= 1'b0;
            loop_l <= 1'b0;
        end else begin
            if (wr_en && reg_addr == 2'd3) c_loop <= write_data[6];
            if (tx_pop) loop_l <= c_loop;
        end
    end
    assign sample_bit = loop_l ? mosi_q : miso;
`else
    assign c_loop     = 1'b0;
    assign sample_bit = miso;
`endif

    assign half_done = (hcnt == div_l);
    assign last_edge = (ecnt == EW'(EDGES - 1));
    assign leading   = toggle & ~ecnt[0];
    assign trailing  = toggle & ecnt[0];
    assign sample_ev = cpha_l ? trailing : leading;
    assign shift_ev  = cpha_l ? leading : (trailing & ~last_edge);
    // With cpha=1 the final bit is sampled on the very edge that pushes the word.
    assign rx_word   = cpha_l ? {rx_sr[DATA_W-2:0], sample_bit} : rx_sr;

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (hard_reset) state <= IDLE;
        else            state <= next_state;
    end

    // NOTE: every output of this block is defaulted first so no latch can be inferred.
    always_comb begin
        next_state = state;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        toggle     = 1'b0;
        case (state)
            IDLE: begin
                if (c_enable && !tx_empty) begin
                    next_state = SETUP;
                    tx_pop     = 1'b1;
                end
            end
            SETUP: if (half_done) next_state = SHIFT;
            SHIFT: begin
                if (half_done) begin
                    toggle = 1'b1;
                    if (last_edge) begin
                        next_state = HOLD;
                        rx_push    = 1'b1;
                    end
                end
            end
            HOLD:    if (half_done) next_state = GAP;
            GAP:     if (half_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (hard_reset) begin
            cpha_l <= 1'b0;
            div_l  <= '0;
            hcnt   <= '0;
            ecnt   <= '0;
            tx_sr  <= '0;
            rx_sr  <= '0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            ss_n_q <= '1;
        end else if (state == IDLE) begin
            sclk_q <= c_cpol;
            ss_n_q <= '1;
            hcnt   <= '0;
            ecnt   <= '0;
            if (tx_pop) begin
                cpha_l <= c_cpha;
                div_l  <= c_div;
                ss_n_q <= ss_decode(c_ss_sel);
                if (c_cpha) begin
                    tx_sr <= tx_head;
                end else begin
                    mosi_q <= tx_head[DATA_W-1];
                    tx_sr  <= tx_head << 1;
                end
            end
        end else begin
            hcnt <= half_done ? '0 : hcnt + 1'b1;
            if (toggle) begin
                sclk_q <= ~sclk_q;
                ecnt   <= ecnt + 1'b1;
            end
            if (sample_ev) rx_sr <= {rx_sr[DATA_W-2:0], sample_bit};
            if (shift_ev) begin
                mosi_q <= tx_sr[DATA_W-1];
                tx_sr  <= tx_sr << 1;
            end
            if (state == HOLD && half_done) ss_n_q <= '1;
        end
    end
endmodule

// File: tb/tb_avalon_spi_master_mc.sv
// Scoreboard bench for avalon_spi_master_mc: RX words are queued at TX write time and checked on RXDATA reads.
// Loopback frames are wired mosi->miso in the bench, so results match with or without SPI_LOOPBACK_EN.

module tb_avalon_spi_master_mc;
    localparam int NUM_SS = 4;
    localparam logic [31:0] EN      = 32'h0000_0001;
    localparam logic [31:0] CPOL    = 32'h0000_0002;
    localparam logic [31:0] CPHA    = 32'h0000_0004;
    localparam logic [31:0] IE_IDLE = 32'h0000_0010;
    localparam logic [31:0] IE_ERR  = 32'h0000_0020;
    localparam logic [31:0] LOOP    = 32'h0000_0040;

    logic              clk = 1'b0;
    logic              hard_reset;
    logic [7:0]        address;
    logic              chip_select, read, write;
    logic [31:0]       write_data;
    logic [31:0]       read_data;
    logic              wait_request, irq, miso, sclk, mosi;
    logic [NUM_SS-1:0] ss_n;

    logic        tb_loop = 1'b1;
    logic        m_cpol = 1'b0, m_cpha = 1'b0;
    logic [31:0] pattern = 32'h3C3C_3C3C;
    logic        slave_bit;
    logic        sclk_prev = 1'b0;
    int          slave_idx = 0;
    int          ss0_low_cnt = 0, ss_any_low_cnt = 0, rise_cnt = 0;

    int          checks = 0, errors = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    avalon_spi_master_mc #(.DATA_W(32), .FIFO_DEPTH(8), .NUM_SS(NUM_SS), .DIV_W(8)) dut (
        .clk(clk), .hard_reset(hard_reset), .address(address), .chip_select(chip_select),
        .read(read), .write(write), .write_data(write_data), .read_data(read_data),
        .wait_request(wait_request), .irq(irq), .miso(miso), .sclk(sclk), .mosi(mosi), .ss_n(ss_n)
    );

    assign slave_bit = (slave_idx >= 0 && slave_idx < 32) ? pattern[5'(31 - slave_idx)] : 1'b0;
    assign miso      = tb_loop ? mosi : slave_bit;

    // Line monitor plus SPI slave model that shifts out `pattern` on the edge opposite to sampling.
    always @(negedge clk) begin
        if (ss_n[0] === 1'b0) ss0_low_cnt++;
        if (ss_n !== {NUM_SS{1'b1}}) ss_any_low_cnt++;
        if (sclk === 1'b1 && sclk_prev === 1'b0) rise_cnt++;
        if (ss_n[0] !== 1'b0) slave_idx = m_cpha ? -1 : 0;
        else if (sclk !== sclk_prev && ((sclk !== m_cpol) == m_cpha)) slave_idx++;
        sclk_prev = sclk;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = {6'd0, a}; write_data = d; chip_select = 1'b1; write = 1'b1;
        @(negedge clk);
        chip_select = 1'b0; write = 1'b0;
    endtask

    task automatic av_read(input logic [1:0] a, output logic [31:0] d, output int waits);
        @(negedge clk);
        address = {6'd0, a}; chip_select = 1'b1; read = 1'b1; waits = 0;
        #1;
        while (wait_request === 1'b1 && waits < 8) begin
            @(negedge clk);
            #1;
            waits++;
        end
        d = read_data;
        @(negedge clk);
        chip_select = 1'b0; read = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] st;
        int          w;
        bit          done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            av_read(2'd2, st, w);
            if (st[0] === 1'b0 && st[1] === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL %s: timeout waiting for idle, status %h", name, st); end
    endtask

    task automatic check_status(input string name, input logic [31:0] exp);
        logic [31:0] st;
        int          w;
        av_read(2'd2, st, w);
        checks++;
        if (st !== exp) begin errors++; $display("FAIL %s: status %h expected %h", name, st, exp); end
    endtask

    task automatic pop_check(input string name);
        logic [31:0] d, exp;
        int          w;
        av_read(2'd1, d, w);
        checks++;
        if (sb.size() == 0) begin
            errors++; $display("FAIL %s: rx %h but scoreboard empty", name, d);
        end else begin
            exp = sb.pop_front();
            if (d !== exp) begin errors++; $display("FAIL %s: rx %h expected %h", name, d, exp); end
        end
    endtask

    task automatic test_reset();
        hard_reset = 1'b1; address = '0; chip_select = 1'b0; read = 1'b0; write = 1'b0; write_data = '0;
        repeat (3) @(negedge clk);
        hard_reset = 1'b0;
        #1;
        checks++;
        if ({read_data, wait_request, irq, sclk, mosi, ss_n} !== {32'd0, 4'b0000, {NUM_SS{1'b1}}}) begin
            errors++;
            $display("FAIL reset_outputs: rd=%h wr=%b irq=%b sclk=%b mosi=%b ss_n=%b", read_data,
                     wait_request, irq, sclk, mosi, ss_n);
        end
        check_status("reset_status", 32'h0000_000A);
    endtask

    task automatic test_regs();
        logic [31:0] d;
        int          w;
        av_write(2'd3, 32'hFFAB_FBBF);
        av_read(2'd3, d, w);
        checks++;
        if (d !== 32'h00AB_0B3F) begin errors++; $display("FAIL control_rw: %h expected %h", d, 32'h00AB_0B3F); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_idle: irq %b expected 1", irq); end
        av_write(2'd1, 32'h1234_5678);
        check_status("rxdata_write_ignored", 32'h0000_000A);
        av_write(2'd3, 32'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_off: irq %b expected 0", irq); end
    endtask

    task automatic test_loopback_mode0();
        int s0, r0;
        tb_loop = 1'b1; m_cpol = 1'b0; m_cpha = 1'b0;
        av_write(2'd3, EN | LOOP | (32'd1 << 16));
        repeat (2) @(negedge clk);
        s0 = ss0_low_cnt; r0 = rise_cnt;
        av_write(2'd0, 32'hA5C3_0F96);
        sb.push_back(32'hA5C3_0F96);
        wait_idle("mode0_idle");
        checks++;
        if (ss0_low_cnt - s0 != 132) begin errors++; $display("FAIL mode0_ss_low: %0d cycles expected 132", ss0_low_cnt - s0); end
        checks++;
        if (rise_cnt - r0 != 32) begin errors++; $display("FAIL mode0_rises: %0d expected 32", rise_cnt - r0); end
        pop_check("mode0_rx");
        check_status("mode0_rx_empty", 32'h0000_000A);
    endtask

    task automatic test_modes();
        for (int m = 1; m <= 3; m++) begin
            logic [1:0] mb;
            int s0;
            mb = m[1:0];
            tb_loop = 1'b0; m_cpol = mb[1]; m_cpha = mb[0];
            av_write(2'd3, EN | (mb[1] ? CPOL : 32'h0) | (mb[0] ? CPHA : 32'h0) | (32'd2 << 16));
            repeat (3) @(negedge clk);
            checks++;
            if (sclk !== mb[1]) begin errors++; $display("FAIL mode%0d_idle_sclk: %b expected %b", m, sclk, mb[1]); end
            s0 = ss0_low_cnt;
            av_write(2'd0, 32'h1234_5678 ^ 32'(m));
            sb.push_back(32'h3C3C_3C3C);
            wait_idle("mode_idle");
            checks++;
            if (ss0_low_cnt - s0 != 198) begin errors++; $display("FAIL mode%0d_ss_low: %0d expected 198", m, ss0_low_cnt - s0); end
            pop_check("mode_rx");
        end
        tb_loop = 1'b1; m_cpol = 1'b0; m_cpha = 1'b0;
        av_write(2'd3, 32'h0);
    endtask

    task automatic test_tx_overflow();
        av_write(2'd3, IE_ERR);
        for (int i = 0; i < 9; i++) begin
            logic [31:0] d;
            d = (32'(i) * 32'h0101_0101) ^ 32'h8000_0001;
            av_write(2'd0, d);
            if (i < 8) sb.push_back(d);
        end
        check_status("tx_full_ovf", 32'h0000_002C);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_err: irq %b expected 1", irq); end
        av_write(2'd2, 32'h0000_0020);
        repeat (2) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_err_clear: irq %b expected 0", irq); end
        check_status("tx_ovf_cleared", 32'h0000_000C);
    endtask

    task automatic test_rx_overrun();
        logic [31:0] st;
        int          w;
        bit          seen = 1'b0;
        tb_loop = 1'b1;
        av_write(2'd3, EN | LOOP);
        for (int i = 0; i < 3000 && !seen; i++) begin
            av_read(2'd2, st, w);
            if (st[1] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL back_to_back_drain: timeout, status %h", st); end
        av_write(2'd0, 32'hCAFE_F00D);
        wait_idle("overrun_idle");
        check_status("rx_full_ovr", 32'h0000_0052);
        for (int i = 0; i < 8; i++) pop_check("overrun_rx_order");
        check_status("rx_drained", 32'h0000_004A);
        av_write(2'd2, 32'h0000_0040);
        check_status("rx_ovr_cleared", 32'h0000_000A);
    endtask

    task automatic test_empty_read();
        logic [31:0] d;
        int          w;
        av_write(2'd3, IE_IDLE);
        repeat (2) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_idle_empty: irq %b expected 1", irq); end
        av_read(2'd1, d, w);
        checks++;
        if (w != 1) begin errors++; $display("FAIL empty_read_waits: %0d expected 1", w); end
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL empty_read_data: %h expected 0", d); end
        av_write(2'd3, EN | LOOP);
        av_write(2'd0, 32'h5A5A_1234);
        sb.push_back(32'h5A5A_1234);
        wait_idle("after_empty_idle");
        pop_check("after_empty_rx");
        check_status("after_empty_status", 32'h0000_000A);
    endtask

    task automatic test_ss_out_of_range();
        int s0;
        av_write(2'd3, EN | LOOP | (32'd5 << 8));
        s0 = ss_any_low_cnt;
        av_write(2'd0, 32'h0F0F_00FF);
        sb.push_back(32'h0F0F_00FF);
        wait_idle("ss_oor_idle");
        checks++;
        if (ss_any_low_cnt != s0) begin errors++; $display("FAIL ss_oor_lines: %0d low cycles expected 0", ss_any_low_cnt - s0); end
        pop_check("ss_oor_rx");
    endtask

    task automatic test_hard_reset();
        logic [31:0] d;
        int          w;
        av_write(2'd3, EN | LOOP | (32'd3 << 16));
        av_write(2'd0, 32'hDEAD_BEEF);
        for (int i = 0; i < 100 && ss_n[0] !== 1'b0; i++) @(negedge clk);
        checks++;
        if (ss_n[0] !== 1'b0) begin errors++; $display("FAIL hr_frame_start: ss_n %b expected ss_n[0]=0", ss_n); end
        repeat (40) @(negedge clk);
        hard_reset = 1'b1;
        @(negedge clk);
        hard_reset = 1'b0;
        checks++;
        if ({sclk, mosi, irq, ss_n} !== {3'b000, {NUM_SS{1'b1}}}) begin
            errors++; $display("FAIL hr_outputs: sclk=%b mosi=%b irq=%b ss_n=%b", sclk, mosi, irq, ss_n);
        end
        check_status("hr_status", 32'h0000_000A);
        av_read(2'd3, d, w);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL hr_control: %h expected 0", d); end
        av_read(2'd1, d, w);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL hr_no_rx_push: %h expected 0", d); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_loopback_mode0();
        test_modes();
        test_tx_overflow();
        test_rx_overrun();
        test_empty_read();
        test_ss_out_of_range();
        test_hard_reset();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left: %0d words expected 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
